// File: rtl/pan_pkg.sv
// Shared pixel-analysis types: RGB cell word, line/frame geometry and a per-channel max helper.
package pan_pkg;

    localparam int CELL_W = 24;
    localparam int CHAN_W = 8;
    localparam int COL_W  = 7;
    localparam int BAND_W = 6;

    localparam int DEF_CELLS_PER_LINE  = 80;
    localparam int DEF_CELL_ROWS       = 24;
    localparam int DEF_BANDS_PER_FRAME = 45;

    typedef logic [CELL_W-1:0] rgb_t;

    // Unsigned per-channel maximum of two packed {R,G,B} words; ties return the common value.
    function automatic rgb_t rgb_max(input rgb_t a, input rgb_t b);
        rgb_t r;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            r[c*CHAN_W +: CHAN_W] = (a[c*CHAN_W +: CHAN_W] > b[c*CHAN_W +: CHAN_W]) ?
                                    a[c*CHAN_W +: CHAN_W] : b[c*CHAN_W +: CHAN_W];
        end
        return r;
    endfunction

endpackage

// File: rtl/cell_acc_ram.sv
// Per-column running-max store: simple dual-port RAM, one write and one registered read per cycle.
module cell_acc_ram
    import pan_pkg::*;
#(
    parameter int DEPTH  = DEF_CELLS_PER_LINE,
    parameter int ADDR_W = $clog2(DEF_CELLS_PER_LINE)
) (
    input  logic              clkn,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  rgb_t              wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output rgb_t              rd_data
);

    rgb_t mem [DEPTH];
    rgb_t rd_data_q;

    // Write port and synchronous read port share the falling edge; a same-address read returns the old word.
    always_ff @(negedge clkn) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/cell_block_max.sv
// Second-stage block max: folds per-cell maxima down a band of lines and emits one block max per column.
module cell_block_max
    import pan_pkg::*;
#(
    parameter int CELLS_PER_LINE  = DEF_CELLS_PER_LINE,
    parameter int CELL_ROWS       = DEF_CELL_ROWS,
    parameter int BANDS_PER_FRAME = DEF_BANDS_PER_FRAME
) (
    input  logic              clkn,
    input  logic              reset,
    input  logic              sof,
    input  logic              valid_max_RGB,
    input  logic [CELL_W-1:0] max_RGB,
    output logic              valid_block_RGB,
    output logic [CELL_W-1:0] block_RGB,
    output logic [COL_W-1:0]  block_col,
    output logic [BAND_W-1:0] block_row
);

    localparam int ADDR_W = $clog2(CELLS_PER_LINE);
    localparam int ROW_W  = (CELL_ROWS > 1) ? $clog2(CELL_ROWS) : 1;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(CELLS_PER_LINE - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(CELL_ROWS - 1);
    localparam logic [BAND_W-1:0] BAND_LAST = BAND_W'(BANDS_PER_FRAME - 1);

    // Position counters
    logic [COL_W-1:0]  col_q,  col_d;
    logic [ROW_W-1:0]  row_q,  row_d;
    logic [BAND_W-1:0] band_q, band_d;
    logic [COL_W-1:0]  cur_col;
    logic [ROW_W-1:0]  cur_row;
    logic [BAND_W-1:0] cur_band;

    // Stage 1: captured input and its tags, RAM read in flight
    logic              s1_valid_q, s1_valid_d;
    rgb_t              s1_rgb_q,   s1_rgb_d;
    logic [COL_W-1:0]  s1_col_q,   s1_col_d;
    logic [ROW_W-1:0]  s1_row_q,   s1_row_d;
    logic [BAND_W-1:0] s1_band_q,  s1_band_d;

    // Stage 2: merge with accumulator and write back
    logic              s2_valid_q, s2_valid_d;
    rgb_t              s2_rgb_q,   s2_rgb_d;
    logic [COL_W-1:0]  s2_col_q,   s2_col_d;
    logic [ROW_W-1:0]  s2_row_q,   s2_row_d;
    logic [BAND_W-1:0] s2_band_q,  s2_band_d;

    // Bypass for a write that lands on the same edge as the read of the same column
    logic              fwd_valid_q, fwd_valid_d;
    rgb_t              fwd_rgb_q,   fwd_rgb_d;

    // Registered outputs
    logic              out_valid_q, out_valid_d;
    rgb_t              out_rgb_q,   out_rgb_d;
    logic [COL_W-1:0]  out_col_q,   out_col_d;
    logic [BAND_W-1:0] out_row_q,   out_row_d;

    rgb_t ram_rd_data;
    rgb_t acc_rgb;
    rgb_t new_rgb;
    logic emit;

    cell_acc_ram #(
        .DEPTH  (CELLS_PER_LINE),
        .ADDR_W (ADDR_W)
    ) u_acc_ram (
        .clkn    (clkn),
        .wr_en   (s2_valid_q && !reset),
        .wr_addr (s2_col_q[ADDR_W-1:0]),
        .wr_data (new_rgb),
        .rd_addr (s1_col_q[ADDR_W-1:0]),
        .rd_data (ram_rd_data)
    );

    // Raster position: sof zeroes the counters before the same-cycle input is tagged, then each input advances them.
    always_comb begin
        cur_col  = sof ? '0 : col_q;
        cur_row  = sof ? '0 : row_q;
        cur_band = sof ? '0 : band_q;
        col_d    = cur_col;
        row_d    = cur_row;
        band_d   = cur_band;
        if (valid_max_RGB) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                if (cur_row == ROW_LAST) begin
                    row_d  = '0;
                    band_d = (cur_band == BAND_LAST) ? '0 : cur_band + 1'b1;
                end else begin
                    row_d = cur_row + 1'b1;
                end
            end else begin
                col_d = cur_col + 1'b1;
            end
        end
    end

    // Two-stage datapath: tag and read, then merge (first band row overwrites), write back and emit on the last row.
    always_comb begin
        s1_valid_d = valid_max_RGB;
        s1_rgb_d   = max_RGB;
        s1_col_d   = cur_col;
        s1_row_d   = cur_row;
        s1_band_d  = cur_band;

        s2_valid_d = s1_valid_q;
        s2_rgb_d   = s1_rgb_q;
        s2_col_d   = s1_col_q;
        s2_row_d   = s1_row_q;
        s2_band_d  = s1_band_q;

        acc_rgb = fwd_valid_q ? fwd_rgb_q : ram_rd_data;
        new_rgb = (s2_row_q == '0) ? s2_rgb_q : rgb_max(acc_rgb, s2_rgb_q);

        fwd_valid_d = s2_valid_q && s1_valid_q && (s2_col_q == s1_col_q);
        fwd_rgb_d   = new_rgb;

        emit        = s2_valid_q && (s2_row_q == ROW_LAST);
        out_valid_d = emit;
        out_rgb_d   = emit ? new_rgb  : '0;
        out_col_d   = emit ? s2_col_q : '0;
        out_row_d   = emit ? s2_band_q : '0;
    end

    // State update; reset drops counters, in-flight valids and outputs on the same edge.
    always_ff @(negedge clkn) begin
        if (reset) begin
            col_q       <= '0;
            row_q       <= '0;
            band_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_rgb_q    <= '0;
            s1_col_q    <= '0;
            s1_row_q    <= '0;
            s1_band_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_rgb_q    <= '0;
            s2_col_q    <= '0;
            s2_row_q    <= '0;
            s2_band_q   <= '0;
            fwd_valid_q <= 1'b0;
            fwd_rgb_q   <= '0;
            out_valid_q <= 1'b0;
            out_rgb_q   <= '0;
            out_col_q   <= '0;
            out_row_q   <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            band_q      <= band_d;
            s1_valid_q  <= s1_valid_d;
            s1_rgb_q    <= s1_rgb_d;
            s1_col_q    <= s1_col_d;
            s1_row_q    <= s1_row_d;
            s1_band_q   <= s1_band_d;
            s2_valid_q  <= s2_valid_d;
            s2_rgb_q    <= s2_rgb_d;
            s2_col_q    <= s2_col_d;
            s2_row_q    <= s2_row_d;
            s2_band_q   <= s2_band_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_rgb_q   <= fwd_rgb_d;
            out_valid_q <= out_valid_d;
            out_rgb_q   <= out_rgb_d;
            out_col_q   <= out_col_d;
            out_row_q   <= out_row_d;
        end
    end

    assign valid_block_RGB = out_valid_q;
    assign block_RGB       = out_rgb_q;
    assign block_col       = out_col_q;
    assign block_row       = out_row_q;

endmodule

// File: tb/tb_cell_block_max.sv
// Bench for cell_block_max on a small 4x3x2 geometry, driven with directed and random cell streams.
module tb_cell_block_max;

    localparam int CPL   = 4;
    localparam int CR    = 3;
    localparam int BPF   = 2;
    localparam int NSLOT = 4096;

    logic        clkn   = 1'b1;
    logic        reset  = 1'b1;
    logic        sof    = 1'b0;
    logic        valid  = 1'b0;
    logic [23:0] maxRgb = 24'h0;

    logic        validBlock;
    logic [23:0] blockRgb;
    logic [6:0]  blockCol;
    logic [5:0]  blockRow;

    cell_block_max #(
        .CELLS_PER_LINE  (CPL),
        .CELL_ROWS       (CR),
        .BANDS_PER_FRAME (BPF)
    ) dut (
        .clkn            (clkn),
        .reset           (reset),
        .sof             (sof),
        .valid_max_RGB   (valid),
        .max_RGB         (maxRgb),
        .valid_block_RGB (validBlock),
        .block_RGB       (blockRgb),
        .block_col       (blockCol),
        .block_row       (blockRow)
    );

    typedef struct packed {
        logic [23:0] rgb;
        logic [6:0]  col;
        logic [5:0]  row;
    } blk_t;

    int          errors  = 0;
    int          checks  = 0;
    int          cyc     = 0;
    bit          running = 1'b1;
    logic [37:0] expSlot [NSLOT];
    blk_t        cap [$];

    int          mCol  = 0;
    int          mRow  = 0;
    int          mBand = 0;
    logic [23:0] mAcc [CPL];

    // Free-running pixel clock; the design acts on its falling edge
    always #5 clkn = ~clkn;

    // Falling-edge count used to line expected results up with cycles
    always @(negedge clkn) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // Every rising edge compares the whole output bundle against the expected slot and captures emitted blocks
    always @(posedge clkn) begin
        if (running && cyc > 0 && cyc < NSLOT) begin
            checkOutput("blk", 64'({validBlock, blockRgb, blockCol, blockRow}), 64'(expSlot[cyc]));
            if (validBlock) begin
                cap.push_back('{rgb: blockRgb, col: blockCol, row: blockRow});
            end
        end
    end

    // Reference: array of column maxima over the band, result appears three rising edges after driving
    task automatic modelStep(input bit r, input bit s, input bit v, input logic [23:0] rgb);
        int a;
        int b;
        logic [23:0] merged;
        if (r) begin
            mCol = 0; mRow = 0; mBand = 0;
            for (int i = 1; i <= 3; i++) begin
                if (cyc + i < NSLOT) expSlot[cyc + i] = '0;
            end
            return;
        end
        if (s) begin
            mCol = 0; mRow = 0; mBand = 0;
        end
        if (!v) return;
        merged = rgb;
        if (mRow != 0) begin
            for (int c = 0; c < 3; c++) begin
                a = int'(mAcc[mCol][c*8 +: 8]);
                b = int'(rgb[c*8 +: 8]);
                merged[c*8 +: 8] = 8'((a > b) ? a : b);
            end
        end
        mAcc[mCol] = merged;
        if (mRow == CR - 1 && cyc + 3 < NSLOT) begin
            expSlot[cyc + 3] = {1'b1, merged, 7'(mCol), 6'(mBand)};
        end
        mCol++;
        if (mCol == CPL) begin
            mCol = 0;
            mRow++;
            if (mRow == CR) begin
                mRow  = 0;
                mBand = (mBand + 1) % BPF;
            end
        end
    endtask

    task automatic applyStimulus(input bit r, input bit s, input bit v, input logic [23:0] rgb);
        reset  = r;
        sof    = s;
        valid  = v;
        maxRgb = rgb;
        modelStep(r, s, v, rgb);
        @(posedge clkn);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    // Directed scenarios followed by a long random run
    initial begin
        logic [23:0] chan [3];
        logic [23:0] rgb;
        logic [7:0]  v8;
        bit          rv;
        bit          rs;

        chan[0] = 24'hFF0000;
        chan[1] = 24'h00FF00;
        chan[2] = 24'h0000FF;
        for (int i = 0; i < NSLOT; i++) expSlot[i] = '0;

        // Reset held while cells keep arriving
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 24'($urandom));
        idleCycles(2);

        $display("[TB] ramp band");
        cap.delete();
        for (int i = 0; i < 12; i++) begin
            v8 = 8'((i / 4) * 4 + (i % 4));
            applyStimulus(1'b0, i == 0, 1'b1, {v8, v8, v8});
        end
        idleCycles(4);
        checkOutput("ramp_count", 64'(cap.size()), 64'd4);
        for (int c = 0; c < 4; c++) begin
            rgb = 24'h080808 + 24'(c) * 24'h010101;
            checkOutput("ramp_blk", 64'(cap[c]), 64'({rgb, 7'(c), 6'd0}));
        end

        $display("[TB] channel independence");
        cap.delete();
        for (int i = 0; i < 12; i++) begin
            rgb = ((i % 4) == 0) ? chan[i / 4] : 24'($urandom);
            applyStimulus(1'b0, 1'b0, 1'b1, rgb);
        end
        idleCycles(4);
        checkOutput("chan_count", 64'(cap.size()), 64'd4);
        checkOutput("chan_blk", 64'(cap[0]), 64'({24'hFFFFFF, 7'd0, 6'd1}));

        $display("[TB] stale accumulator");
        cap.delete();
        for (int i = 0; i < 24; i++) begin
            if (i == 1)               rgb = 24'hFFFFFF;
            else if (i >= 12 && (i % 4) == 1) rgb = 24'h010203;
            else                      rgb = 24'($urandom_range(0, 24'hFFFFFE));
            applyStimulus(1'b0, i == 0, 1'b1, rgb);
        end
        idleCycles(4);
        checkOutput("stale_count", 64'(cap.size()), 64'd8);
        checkOutput("stale_band0", 64'(cap[1]), 64'({24'hFFFFFF, 7'd1, 6'd0}));
        checkOutput("stale_band1", 64'(cap[5]), 64'({24'h010203, 7'd1, 6'd1}));

        $display("[TB] back-to-back with band wrap");
        cap.delete();
        for (int i = 0; i < 24; i++) applyStimulus(1'b0, i == 0, 1'b1, 24'($urandom));
        idleCycles(4);
        checkOutput("b2b_count", 64'(cap.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            checkOutput("b2b_tag", 64'({cap[i].col, cap[i].row}), 64'({7'(i % 4), 6'(i / 4)}));
        end
        cap.delete();
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 1'b1, 24'($urandom));
        idleCycles(4);
        checkOutput("wrap_count", 64'(cap.size()), 64'd4);
        checkOutput("wrap_tag", 64'({cap[3].col, cap[3].row}), 64'({7'd3, 6'd0}));

        $display("[TB] sof mid-band");
        cap.delete();
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, i == 0, 1'b1, 24'($urandom));
        applyStimulus(1'b0, 1'b1, 1'b0, 24'h0);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 1'b1, 24'($urandom));
        idleCycles(4);
        checkOutput("midsof_count", 64'(cap.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("midsof_tag", 64'({cap[i].col, cap[i].row}), 64'({7'(i), 6'd0}));
        end

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            rv = ($urandom_range(0, 9) < 6);
            rs = ($urandom_range(0, 59) == 0);
            if (i == 200 || i == 201) applyStimulus(1'b1, 1'b0, rv, 24'($urandom));
            else                      applyStimulus(1'b0, rs, rv, 24'($urandom));
        end
        idleCycles(5);

        running = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
